// File: rtl/aes_encrypt_serial_pkg.sv
// ============================================================================
// Module  : aes_encrypt_serial_pkg
// Brief   : Shared AES types and GF(2^8) helpers for the byte-serial cipher cores.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_encrypt_serial_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SUBSHIFT = 3'd2,
        ST_MIX      = 3'd3,
        ST_ADDKEY   = 3'd4,
        ST_DONE     = 3'd5
    } aes_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Byte index r+4c is fed from r+4*((c+r)%4) to realise ShiftRows on the fly.
    function automatic logic [3:0] shift_src(input logic [3:0] idx);
        logic [1:0] col;
        col = idx[3:2] + idx[1:0];
        return {col, idx[1:0]};
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3,
                a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3,
                a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3),
                gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_encrypt_serial_sbox.sv
// ============================================================================
// Module  : aes_encrypt_serial_sbox
// Brief   : Combinational AES forward S-box, 8 bits in, 8 bits out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_encrypt_serial_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);

    always_comb begin
        s_o = 8'h00;
        case (a_i)
            8'h00: s_o = 8'h63; 8'h01: s_o = 8'h7c; 8'h02: s_o = 8'h77; 8'h03: s_o = 8'h7b; 8'h04: s_o = 8'hf2; 8'h05: s_o = 8'h6b; 8'h06: s_o = 8'h6f; 8'h07: s_o = 8'hc5;
            8'h08: s_o = 8'h30; 8'h09: s_o = 8'h01; 8'h0a: s_o = 8'h67; 8'h0b: s_o = 8'h2b; 8'h0c: s_o = 8'hfe; 8'h0d: s_o = 8'hd7; 8'h0e: s_o = 8'hab; 8'h0f: s_o = 8'h76;
            8'h10: s_o = 8'hca; 8'h11: s_o = 8'h82; 8'h12: s_o = 8'hc9; 8'h13: s_o = 8'h7d; 8'h14: s_o = 8'hfa; 8'h15: s_o = 8'h59; 8'h16: s_o = 8'h47; 8'h17: s_o = 8'hf0;
            8'h18: s_o = 8'had; 8'h19: s_o = 8'hd4; 8'h1a: s_o = 8'ha2; 8'h1b: s_o = 8'haf; 8'h1c: s_o = 8'h9c; 8'h1d: s_o = 8'ha4; 8'h1e: s_o = 8'h72; 8'h1f: s_o = 8'hc0;
            8'h20: s_o = 8'hb7; 8'h21: s_o = 8'hfd; 8'h22: s_o = 8'h93; 8'h23: s_o = 8'h26; 8'h24: s_o = 8'h36; 8'h25: s_o = 8'h3f; 8'h26: s_o = 8'hf7; 8'h27: s_o = 8'hcc;
            8'h28: s_o = 8'h34; 8'h29: s_o = 8'ha5; 8'h2a: s_o = 8'he5; 8'h2b: s_o = 8'hf1; 8'h2c: s_o = 8'h71; 8'h2d: s_o = 8'hd8; 8'h2e: s_o = 8'h31; 8'h2f: s_o = 8'h15;
            8'h30: s_o = 8'h04; 8'h31: s_o = 8'hc7; 8'h32: s_o = 8'h23; 8'h33: s_o = 8'hc3; 8'h34: s_o = 8'h18; 8'h35: s_o = 8'h96; 8'h36: s_o = 8'h05; 8'h37: s_o = 8'h9a;
            8'h38: s_o = 8'h07; 8'h39: s_o = 8'h12; 8'h3a: s_o = 8'h80; 8'h3b: s_o = 8'he2; 8'h3c: s_o = 8'heb; 8'h3d: s_o = 8'h27; 8'h3e: s_o = 8'hb2; 8'h3f: s_o = 8'h75;
            8'h40: s_o = 8'h09; 8'h41: s_o = 8'h83; 8'h42: s_o = 8'h2c; 8'h43: s_o = 8'h1a; 8'h44: s_o = 8'h1b; 8'h45: s_o = 8'h6e; 8'h46: s_o = 8'h5a; 8'h47: s_o = 8'ha0;
            8'h48: s_o = 8'h52; 8'h49: s_o = 8'h3b; 8'h4a: s_o = 8'hd6; 8'h4b: s_o = 8'hb3; 8'h4c: s_o = 8'h29; 8'h4d: s_o = 8'he3; 8'h4e: s_o = 8'h2f; 8'h4f: s_o = 8'h84;
            8'h50: s_o = 8'h53; 8'h51: s_o = 8'hd1; 8'h52: s_o = 8'h00; 8'h53: s_o = 8'hed; 8'h54: s_o = 8'h20; 8'h55: s_o = 8'hfc; 8'h56: s_o = 8'hb1; 8'h57: s_o = 8'h5b;
            8'h58: s_o = 8'h6a; 8'h59: s_o = 8'hcb; 8'h5a: s_o = 8'hbe; 8'h5b: s_o = 8'h39; 8'h5c: s_o = 8'h4a; 8'h5d: s_o = 8'h4c; 8'h5e: s_o = 8'h58; 8'h5f: s_o = 8'hcf;
            8'h60: s_o = 8'hd0; 8'h61: s_o = 8'hef; 8'h62: s_o = 8'haa; 8'h63: s_o = 8'hfb; 8'h64: s_o = 8'h43; 8'h65: s_o = 8'h4d; 8'h66: s_o = 8'h33; 8'h67: s_o = 8'h85;
            8'h68: s_o = 8'h45; 8'h69: s_o = 8'hf9; 8'h6a: s_o = 8'h02; 8'h6b: s_o = 8'h7f; 8'h6c: s_o = 8'h50; 8'h6d: s_o = 8'h3c; 8'h6e: s_o = 8'h9f; 8'h6f: s_o = 8'ha8;
            8'h70: s_o = 8'h51; 8'h71: s_o = 8'ha3; 8'h72: s_o = 8'h40; 8'h73: s_o = 8'h8f; 8'h74: s_o = 8'h92; 8'h75: s_o = 8'h9d; 8'h76: s_o = 8'h38; 8'h77: s_o = 8'hf5;
            8'h78: s_o = 8'hbc; 8'h79: s_o = 8'hb6; 8'h7a: s_o = 8'hda; 8'h7b: s_o = 8'h21; 8'h7c: s_o = 8'h10; 8'h7d: s_o = 8'hff; 8'h7e: s_o = 8'hf3; 8'h7f: s_o = 8'hd2;
            8'h80: s_o = 8'hcd; 8'h81: s_o = 8'h0c; 8'h82: s_o = 8'h13; 8'h83: s_o = 8'hec; 8'h84: s_o = 8'h5f; 8'h85: s_o = 8'h97; 8'h86: s_o = 8'h44; 8'h87: s_o = 8'h17;
            8'h88: s_o = 8'hc4; 8'h89: s_o = 8'ha7; 8'h8a: s_o = 8'h7e; 8'h8b: s_o = 8'h3d; 8'h8c: s_o = 8'h64; 8'h8d: s_o = 8'h5d; 8'h8e: s_o = 8'h19; 8'h8f: s_o = 8'h73;
            8'h90: s_o = 8'h60; 8'h91: s_o = 8'h81; 8'h92: s_o = 8'h4f; 8'h93: s_o = 8'hdc; 8'h94: s_o = 8'h22; 8'h95: s_o = 8'h2a; 8'h96: s_o = 8'h90; 8'h97: s_o = 8'h88;
            8'h98: s_o = 8'h46; 8'h99: s_o = 8'hee; 8'h9a: s_o = 8'hb8; 8'h9b: s_o = 8'h14; 8'h9c: s_o = 8'hde; 8'h9d: s_o = 8'h5e; 8'h9e: s_o = 8'h0b; 8'h9f: s_o = 8'hdb;
            8'ha0: s_o = 8'he0; 8'ha1: s_o = 8'h32; 8'ha2: s_o = 8'h3a; 8'ha3: s_o = 8'h0a; 8'ha4: s_o = 8'h49; 8'ha5: s_o = 8'h06; 8'ha6: s_o = 8'h24; 8'ha7: s_o = 8'h5c;
            8'ha8: s_o = 8'hc2; 8'ha9: s_o = 8'hd3; 8'haa: s_o = 8'hac; 8'hab: s_o = 8'h62; 8'hac: s_o = 8'h91; 8'had: s_o = 8'h95; 8'hae: s_o = 8'he4; 8'haf: s_o = 8'h79;
            8'hb0: s_o = 8'he7; 8'hb1: s_o = 8'hc8; 8'hb2: s_o = 8'h37; 8'hb3: s_o = 8'h6d; 8'hb4: s_o = 8'h8d; 8'hb5: s_o = 8'hd5; 8'hb6: s_o = 8'h4e; 8'hb7: s_o = 8'ha9;
            8'hb8: s_o = 8'h6c; 8'hb9: s_o = 8'h56; 8'hba: s_o = 8'hf4; 8'hbb: s_o = 8'hea; 8'hbc: s_o = 8'h65; 8'hbd: s_o = 8'h7a; 8'hbe: s_o = 8'hae; 8'hbf: s_o = 8'h08;
            8'hc0: s_o = 8'hba; 8'hc1: s_o = 8'h78; 8'hc2: s_o = 8'h25; 8'hc3: s_o = 8'h2e; 8'hc4: s_o = 8'h1c; 8'hc5: s_o = 8'ha6; 8'hc6: s_o = 8'hb4; 8'hc7: s_o = 8'hc6;
            8'hc8: s_o = 8'he8; 8'hc9: s_o = 8'hdd; 8'hca: s_o = 8'h74; 8'hcb: s_o = 8'h1f; 8'hcc: s_o = 8'h4b; 8'hcd: s_o = 8'hbd; 8'hce: s_o = 8'h8b; 8'hcf: s_o = 8'h8a;
            8'hd0: s_o = 8'h70; 8'hd1: s_o = 8'h3e; 8'hd2: s_o = 8'hb5; 8'hd3: s_o = 8'h66; 8'hd4: s_o = 8'h48; 8'hd5: s_o = 8'h03; 8'hd6: s_o = 8'hf6; 8'hd7: s_o = 8'h0e;
            8'hd8: s_o = 8'h61; 8'hd9: s_o = 8'h35; 8'hda: s_o = 8'h57; 8'hdb: s_o = 8'hb9; 8'hdc: s_o = 8'h86; 8'hdd: s_o = 8'hc1; 8'hde: s_o = 8'h1d; 8'hdf: s_o = 8'h9e;
            8'he0: s_o = 8'he1; 8'he1: s_o = 8'hf8; 8'he2: s_o = 8'h98; 8'he3: s_o = 8'h11; 8'he4: s_o = 8'h69; 8'he5: s_o = 8'hd9; 8'he6: s_o = 8'h8e; 8'he7: s_o = 8'h94;
            8'he8: s_o = 8'h9b; 8'he9: s_o = 8'h1e; 8'hea: s_o = 8'h87; 8'heb: s_o = 8'he9; 8'hec: s_o = 8'hce; 8'hed: s_o = 8'h55; 8'hee: s_o = 8'h28; 8'hef: s_o = 8'hdf;
            8'hf0: s_o = 8'h8c; 8'hf1: s_o = 8'ha1; 8'hf2: s_o = 8'h89; 8'hf3: s_o = 8'h0d; 8'hf4: s_o = 8'hbf; 8'hf5: s_o = 8'he6; 8'hf6: s_o = 8'h42; 8'hf7: s_o = 8'h68;
            8'hf8: s_o = 8'h41; 8'hf9: s_o = 8'h99; 8'hfa: s_o = 8'h2d; 8'hfb: s_o = 8'h0f; 8'hfc: s_o = 8'hb0; 8'hfd: s_o = 8'h54; 8'hfe: s_o = 8'hbb; 8'hff: s_o = 8'h16;
            default: s_o = 8'h00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/aes_encrypt_serial.sv
// ============================================================================
// Module  : aes_encrypt_serial
// Brief   : Byte-serial AES forward cipher; round keys read from an external store.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_encrypt_serial
    import aes_encrypt_serial_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_byte,
    output logic [7:0]   key_addr,
    input  logic [7:0]   key_byte,
    output logic [127:0] ciphertext,
    output logic         done
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    aes_state_e   fsm_q,    fsm_d;
    logic [3:0]   idx_q,    idx_d;
    logic [3:0]   round_q,  round_d;
    logic [127:0] state_q,  state_d;
    logic [127:0] shadow_q, shadow_d;
    logic [127:0] ct_q,     ct_d;
    logic         done_q,   done_d;

    logic         w_xfer;
    logic [6:0]   w_byte_base;
    logic [6:0]   w_src_base;
    logic [6:0]   w_col_base;
    logic [7:0]   w_sbox_in;
    logic [7:0]   w_sbox_out;

    // Byte k of the state lives at bits [8*(15-k) +: 8]; 15-k is ~k for a 4-bit k.
    assign w_byte_base = {~idx_q, 3'b000};
    assign w_src_base  = {~shift_src(idx_q), 3'b000};
    assign w_col_base  = {~idx_q[1:0], 5'b00000};
    assign w_sbox_in   = state_q[w_src_base +: 8];

    aes_encrypt_serial_sbox u_sbox (
        .a_i (w_sbox_in),
        .s_o (w_sbox_out)
    );

    assign in_ready   = reset_n & ((fsm_q == ST_IDLE) | (fsm_q == ST_LOAD));
    assign w_xfer     = in_valid & in_ready;
    assign key_addr   = {round_q, idx_q};
    assign ciphertext = ct_q;
    assign done       = done_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q    <= ST_IDLE;
            idx_q    <= 4'd0;
            round_q  <= 4'd0;
            state_q  <= '0;
            shadow_q <= '0;
            ct_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            idx_q    <= idx_d;
            round_q  <= round_d;
            state_q  <= state_d;
            shadow_q <= shadow_d;
            ct_q     <= ct_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        idx_d    = idx_q;
        round_d  = round_q;
        state_d  = state_q;
        shadow_d = shadow_q;
        ct_d     = ct_q;
        done_d   = 1'b0;

        unique case (fsm_q)
            ST_IDLE, ST_LOAD: begin
                if (w_xfer) begin
                    state_d[w_byte_base +: 8] = in_byte ^ key_byte;
                    idx_d = idx_q + 4'd1;
                    fsm_d = ST_LOAD;
                    if (idx_q == 4'd15) begin
                        round_d = 4'd1;
                        fsm_d   = ST_SUBSHIFT;
                    end
                end
            end
            ST_SUBSHIFT: begin
                // Shadow keeps unshifted source bytes intact until the whole row pass is done.
                shadow_d[w_byte_base +: 8] = w_sbox_out;
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = shadow_d;
                    fsm_d   = (round_q == LAST_ROUND) ? ST_ADDKEY : ST_MIX;
                end
            end
            ST_MIX: begin
                state_d[w_col_base +: 32] = mix_column(state_q[w_col_base +: 32]);
                idx_d = idx_q + 4'd1;
                if (idx_q[1:0] == 2'd3) begin
                    idx_d = 4'd0;
                    fsm_d = ST_ADDKEY;
                end
            end
            ST_ADDKEY: begin
                state_d[w_byte_base +: 8] = state_q[w_byte_base +: 8] ^ key_byte;
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    if (round_q == LAST_ROUND) begin
                        fsm_d = ST_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        fsm_d   = ST_SUBSHIFT;
                    end
                end
            end
            ST_DONE: begin
                ct_d    = state_q;
                done_d  = 1'b1;
                round_d = 4'd0;
                idx_d   = 4'd0;
                fsm_d   = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
